alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares the single execute-stage ALU between two requesters: requester 0 is the main execute pipe and requester 1 is the branch/address helper. Operations are granted round-robin, issued through a registered operand stage into the combinational ALU, and returned through a registered result stage. Both the request and response sides use a valid/ready handshake, and backpressure propagates through both stages.

## Interface
- INPUT_WIDTH, 32, operand/result width
- TAG_WIDTH, 4, requester-supplied tag returned with the result
- ALU_NOP, 5'b00000, opcode driven to the ALU when the operand stage is empty
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  reset; synchronous, active-low
- FLUSH  in  1  synchronous kill of all in-flight operations
- REQ_VALID_0 / REQ_VALID_1  in  1  request valid
- REQ_READY_0 / REQ_READY_1  out  1  request accepted this cycle
- REQ_IN1_x, REQ_IN2_x  in  INPUT_WIDTH  operands
- REQ_SHAMT_x  in  5  shift amount
- REQ_OP_x  in  5  ALU opcode (ALU_ADD=5'b00001, ALU_SUB=5'b00010, ALU_BEQ=5'b01100, …)
- REQ_TAG_x  in  TAG_WIDTH  tag
- ALU_IN1, ALU_IN2  out  INPUT_WIDTH  to ALU
- SHIFT_AMOUNT  out  5  to ALU
- ALU_INSTRUCTION  out  5  to ALU
- ALU_OUT  in  INPUT_WIDTH  from ALU, combinational
- BRANCH_TAKEN  in  1  from ALU, combinational
- RESP_VALID  out  1  result valid
- RESP_READY  in  1  consumer accepts the result
- RESP_ID  out  1  requester index of the result
- RESP_TAG  out  TAG_WIDTH  echoed tag
- RESP_DATA  out  INPUT_WIDTH  captured ALU_OUT
- RESP_BRANCH  out  1  captured BRANCH_TAKEN

## Operation
- Stage S1 is the operand register: valid, id, tag, in1, in2, shamt, op. Stage S2 is the result register: valid, id, tag, data, branch.
- ALU drive: when S1 is valid, ALU_IN1, ALU_IN2, SHIFT_AMOUNT and ALU_INSTRUCTION come from S1. When S1 is empty, all four are driven to zero, with ALU_INSTRUCTION = ALU_NOP.
- Advance conditions:
  - s2_free = !S2.valid || RESP_READY
  - s1_adv = S1.valid && s2_free
  - s1_free = !S1.valid || s1_adv
- Arbitration uses a 1-bit pointer `prio` that names the preferred requester.
  - If both requesters are valid, grant goes to `prio`; otherwise grant goes to the single valid requester.
  - REQ_READY_g = s1_free && REQ_VALID_g && grant==g && !FLUSH && RST_N. The other requester's READY is 0.
- On acceptance:
  - S1 loads the granted payload and id.
  - `prio` becomes !granted, so it toggles only on acceptance.
- On s1_adv: S2 loads valid=1, id, tag, data=ALU_OUT, branch=BRANCH_TAKEN.
- When S2 is valid, RESP_READY=1 and no s1_adv occurs, S2.valid clears.
- Requesters hold valid and payload stable until READY. Dropping valid before READY is permitted; no state changes.
- Opcode values are not checked. Any 5-bit op, including ALU_NOP, is accepted and its ALU result is returned unchanged.

## Timing
- Reset (RST_N=0 at an edge) sets:
  - RESP_VALID=0, RESP_ID=0, RESP_TAG=0, RESP_DATA=0, RESP_BRANCH=0
  - S1 empty, so ALU_* outputs are 0
  - prio=0
  - REQ_READY_x=0 while RST_N is low
- Reset mid-operation discards S1 and S2 contents with no response.
- Latency: a request accepted at edge t produces RESP_VALID=1 in the cycle after edge t+1 (2 cycles) when unstalled.
- Throughput: one operation per cycle sustained while RESP_READY=1.
- Full pipe (S1 and S2 valid, RESP_READY=0): both REQ_READY=0. RESP_* and ALU_* outputs hold stable.
- Simultaneous RESP_READY=1 on a full pipe: S2 takes S1's result, S1 takes the new grant, all at the same edge.
- FLUSH=1 at an edge:
  - S1.valid and S2.valid clear.
  - No grant occurs and prio is unchanged.
  - FLUSH overrides any same-cycle handshake.
  - Data registers need not clear, but RESP_VALID must be 0 the next cycle.
- S2 outputs change only on edges. No combinational path from ALU_OUT to RESP_*.

## Test plan
- Single request: REQ_0 ADD in1=3, in2=4, tag=5 -> REQ_READY_0=1 for one cycle; 2 cycles later RESP_VALID=1, DATA=7, ID=0, TAG=5, BRANCH=0.
- Both valid every cycle with RESP_READY=1 -> grants alternate 0,1,0,1 starting at 0; responses return in grant order at one per cycle.
- Branch: REQ_1 op=5'b01100 (BEQ), in1=in2=9 -> RESP_BRANCH=1, ID=1. Repeat with in2=8 -> RESP_BRANCH=0.
- Backpressure: hold RESP_READY=0 with both requesters valid -> exactly two accepts, then READY=0. RESP_DATA is stable for 10 cycles. Releasing RESP_READY drains results in order with no loss or duplicate.
- FLUSH with S1 and S2 full plus a pending request -> next cycle RESP_VALID=0, no READY in the flush cycle, prio unchanged; the next request completes normally.
- RST_N=0 asserted mid-stream -> the next cycle shows all outputs at reset values and ALU_INSTRUCTION=0. After release, the first grant with both requesters valid goes to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a
// registered operand stage (S1) and a registered result stage (S2).
module alu_share_arbiter #(
  parameter int         INPUT_WIDTH = 32,
  parameter int         TAG_WIDTH   = 4,
  parameter logic [4:0] ALU_NOP     = 5'b00000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FLUSH,

  input  logic                   REQ_VALID_0,
  output logic                   REQ_READY_0,
  input  logic [INPUT_WIDTH-1:0] REQ_IN1_0,
  input  logic [INPUT_WIDTH-1:0] REQ_IN2_0,
  input  logic [4:0]             REQ_SHAMT_0,
  input  logic [4:0]             REQ_OP_0,
  input  logic [TAG_WIDTH-1:0]   REQ_TAG_0,

  input  logic                   REQ_VALID_1,
  output logic                   REQ_READY_1,
  input  logic [INPUT_WIDTH-1:0] REQ_IN1_1,
  input  logic [INPUT_WIDTH-1:0] REQ_IN2_1,
  input  logic [4:0]             REQ_SHAMT_1,
  input  logic [4:0]             REQ_OP_1,
  input  logic [TAG_WIDTH-1:0]   REQ_TAG_1,

  output logic [INPUT_WIDTH-1:0] ALU_IN1,
  output logic [INPUT_WIDTH-1:0] ALU_IN2,
  output logic [4:0]             SHIFT_AMOUNT,
  output logic [4:0]             ALU_INSTRUCTION,
  input  logic [INPUT_WIDTH-1:0] ALU_OUT,
  input  logic                   BRANCH_TAKEN,

  output logic                   RESP_VALID,
  input  logic                   RESP_READY,
  output logic                   RESP_ID,
  output logic [TAG_WIDTH-1:0]   RESP_TAG,
  output logic [INPUT_WIDTH-1:0] RESP_DATA,
  output logic                   RESP_BRANCH
);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]   tag;
    logic [INPUT_WIDTH-1:0] in1;
    logic [INPUT_WIDTH-1:0] in2;
    logic [4:0]             shamt;
    logic [4:0]             op;
  } payload_t;

  // S1 operand register
  logic     s1_valid;
  logic     s1_id;
  payload_t s1_pl;

  // S2 result register
  logic                   s2_valid;
  logic                   s2_id;
  logic [TAG_WIDTH-1:0]   s2_tag;
  logic [INPUT_WIDTH-1:0] s2_data;
  logic                   s2_branch;

  logic     prio;
  logic     grant;
  logic     accept;
  logic     s2_free;
  logic     s1_adv;
  logic     s1_free;
  payload_t pl_0;
  payload_t pl_1;
  payload_t granted_pl;

  assign pl_0 = '{tag: REQ_TAG_0, in1: REQ_IN1_0, in2: REQ_IN2_0,
                  shamt: REQ_SHAMT_0, op: REQ_OP_0};
  assign pl_1 = '{tag: REQ_TAG_1, in1: REQ_IN1_1, in2: REQ_IN2_1,
                  shamt: REQ_SHAMT_1, op: REQ_OP_1};

  assign s2_free = !s2_valid || RESP_READY;
  assign s1_adv  = s1_valid && s2_free;
  assign s1_free = !s1_valid || s1_adv;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = 1'b0;
    if (REQ_VALID_0 && REQ_VALID_1) grant = prio;
    else                            grant = REQ_VALID_1;
  end

  // READY is gated by FLUSH and RST_N so neither side sees a phantom handshake.
  assign REQ_READY_0 = s1_free && REQ_VALID_0 && !grant && !FLUSH && RST_N;
  assign REQ_READY_1 = s1_free && REQ_VALID_1 &&  grant && !FLUSH && RST_N;
  assign accept      = REQ_READY_0 || REQ_READY_1;
  assign granted_pl  = grant ? pl_1 : pl_0;

  always_comb begin
    ALU_IN1         = '0;
    ALU_IN2         = '0;
    SHIFT_AMOUNT    = '0;
    ALU_INSTRUCTION = ALU_NOP;
    if (s1_valid) begin
      ALU_IN1         = s1_pl.in1;
      ALU_IN2         = s1_pl.in2;
      SHIFT_AMOUNT    = s1_pl.shamt;
      ALU_INSTRUCTION = s1_pl.op;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge CLK) begin
    // NOTE: data registers are reset too, because the reset state of
    // RESP_* is architecturally visible, not just the valid bits.
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_pl    <= '0;
      prio     <= 1'b0;
    end else if (FLUSH) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_id    <= grant;
      s1_pl    <= granted_pl;
      prio     <= !grant;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s2_valid  <= 1'b0;
      s2_id     <= 1'b0;
      s2_tag    <= '0;
      s2_data   <= '0;
      s2_branch <= 1'b0;
    end else if (FLUSH) begin
      s2_valid  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid  <= 1'b1;
      s2_id     <= s1_id;
      s2_tag    <= s1_pl.tag;
      s2_data   <= ALU_OUT;
      s2_branch <= BRANCH_TAKEN;
    end else if (s2_valid && RESP_READY) begin
      s2_valid  <= 1'b0;
    end
  end

  assign RESP_VALID  = s2_valid;
  assign RESP_ID     = s2_id;
  assign RESP_TAG    = s2_tag;
  assign RESP_DATA   = s2_data;
  assign RESP_BRANCH = s2_branch;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a tiny combinational ALU stands in
// for the execute ALU; expected values are written out by hand.
module tb_alu_share_arbiter;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_BEQ = 5'b01100;

  logic          CLK = 1'b0;
  logic          RST_N, FLUSH;
  logic          REQ_VALID_0, REQ_READY_0, REQ_VALID_1, REQ_READY_1;
  logic [W-1:0]  REQ_IN1_0, REQ_IN2_0, REQ_IN1_1, REQ_IN2_1;
  logic [4:0]    REQ_SHAMT_0, REQ_OP_0, REQ_SHAMT_1, REQ_OP_1;
  logic [TW-1:0] REQ_TAG_0, REQ_TAG_1;
  logic [W-1:0]  ALU_IN1, ALU_IN2, ALU_OUT;
  logic [4:0]    SHIFT_AMOUNT, ALU_INSTRUCTION;
  logic          BRANCH_TAKEN;
  logic          RESP_VALID, RESP_READY, RESP_ID, RESP_BRANCH;
  logic [TW-1:0] RESP_TAG;
  logic [W-1:0]  RESP_DATA;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // ADD, SUB, BEQ behave as named; anything else returns in1 ^ in2.
  always_comb begin
    ALU_OUT      = ALU_IN1 ^ ALU_IN2;
    BRANCH_TAKEN = 1'b0;
    case (ALU_INSTRUCTION)
      OP_ADD:  ALU_OUT = ALU_IN1 + ALU_IN2;
      OP_SUB:  ALU_OUT = ALU_IN1 - ALU_IN2;
      OP_BEQ:  BRANCH_TAKEN = (ALU_IN1 == ALU_IN2);
      default: ;
    endcase
  end

  alu_share_arbiter #(.INPUT_WIDTH(W), .TAG_WIDTH(TW), .ALU_NOP(5'b00000)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .REQ_VALID_0(REQ_VALID_0), .REQ_READY_0(REQ_READY_0),
    .REQ_IN1_0(REQ_IN1_0), .REQ_IN2_0(REQ_IN2_0), .REQ_SHAMT_0(REQ_SHAMT_0),
    .REQ_OP_0(REQ_OP_0), .REQ_TAG_0(REQ_TAG_0),
    .REQ_VALID_1(REQ_VALID_1), .REQ_READY_1(REQ_READY_1),
    .REQ_IN1_1(REQ_IN1_1), .REQ_IN2_1(REQ_IN2_1), .REQ_SHAMT_1(REQ_SHAMT_1),
    .REQ_OP_1(REQ_OP_1), .REQ_TAG_1(REQ_TAG_1),
    .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .SHIFT_AMOUNT(SHIFT_AMOUNT),
    .ALU_INSTRUCTION(ALU_INSTRUCTION), .ALU_OUT(ALU_OUT), .BRANCH_TAKEN(BRANCH_TAKEN),
    .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_ID(RESP_ID),
    .RESP_TAG(RESP_TAG), .RESP_DATA(RESP_DATA), .RESP_BRANCH(RESP_BRANCH)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] t);
    REQ_VALID_0 = v; REQ_OP_0 = op; REQ_IN1_0 = a; REQ_IN2_0 = b; REQ_TAG_0 = t;
  endtask

  task automatic drive1(input logic v, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [TW-1:0] t);
    REQ_VALID_1 = v; REQ_OP_1 = op; REQ_IN1_1 = a; REQ_IN2_1 = b; REQ_TAG_1 = t;
  endtask

  task automatic check_resp(input string tag, input logic [W-1:0] data,
                            input logic id, input logic [TW-1:0] t);
    check({tag, "_valid"}, RESP_VALID, 1'b1);
    check({tag, "_data"},  RESP_DATA,  data);
    check({tag, "_id"},    RESP_ID,    id);
    check({tag, "_tag"},   RESP_TAG,   t);
  endtask

  logic [W-1:0]  rr_data [4] = '{32'd100, 32'd50, 32'd101, 32'd49};
  logic          rr_id   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [TW-1:0] rr_tag  [4] = '{4'd0, 4'd8, 4'd1, 4'd9};

  initial begin
    int c0, c1;
    RST_N = 1'b0; FLUSH = 1'b0; RESP_READY = 1'b0;
    REQ_SHAMT_0 = 5'd0; REQ_SHAMT_1 = 5'd0;
    drive0(1'b1, OP_ADD, 32'd1, 32'd1, 4'd0);
    drive1(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);

    // Reset state
    tick(); tick();
    check("rst_ready0", REQ_READY_0, 1'b0);
    check("rst_resp_valid", RESP_VALID, 1'b0);
    check("rst_resp_data", RESP_DATA, 32'd0);
    check("rst_alu_instr", ALU_INSTRUCTION, 5'd0);
    check("rst_alu_in1", ALU_IN1, 32'd0);
    RST_N = 1'b1;
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    tick();

    // Single ADD from requester 0
    RESP_READY = 1'b1;
    drive0(1'b1, OP_ADD, 32'd3, 32'd4, 4'd5);
    settle();
    check("single_ready0", REQ_READY_0, 1'b1);
    check("single_ready1", REQ_READY_1, 1'b0);
    tick();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    settle();
    check("single_s1_in1", ALU_IN1, 32'd3);
    check("single_s1_op", ALU_INSTRUCTION, OP_ADD);
    check("single_lat1_valid", RESP_VALID, 1'b0);
    tick();
    check_resp("single", 32'd7, 1'b0, 4'd5);
    check("single_branch", RESP_BRANCH, 1'b0);
    tick();
    check("single_drained", RESP_VALID, 1'b0);

    // BEQ from requester 1, taken then not taken
    drive1(1'b1, OP_BEQ, 32'd9, 32'd9, 4'd2);
    settle();
    check("beq_t_ready1", REQ_READY_1, 1'b1);
    tick();
    drive1(1'b0, OP_BEQ, 32'd0, 32'd0, 4'd0);
    tick();
    check_resp("beq_t", 32'd0, 1'b1, 4'd2);
    check("beq_t_branch", RESP_BRANCH, 1'b1);
    drive1(1'b1, OP_BEQ, 32'd9, 32'd8, 4'd3);
    settle();
    check("beq_nt_ready1", REQ_READY_1, 1'b1);
    tick();
    drive1(1'b0, OP_BEQ, 32'd0, 32'd0, 4'd0);
    tick();
    check_resp("beq_nt", 32'd1, 1'b1, 4'd3);
    check("beq_nt_branch", RESP_BRANCH, 1'b0);
    tick();

    // Round robin, both valid every cycle; prio is 0 here
    c0 = 0; c1 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive0(1'b1, OP_ADD, W'(c0), 32'd100, TW'(c0));
        drive1(1'b1, OP_SUB, 32'd50, W'(c1), TW'(8 + c1));
        settle();
        check($sformatf("rr%0d_ready0", i), REQ_READY_0, (i % 2) == 0);
        check($sformatf("rr%0d_ready1", i), REQ_READY_1, (i % 2) == 1);
      end else begin
        drive0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
      end
      tick();
      if (i < 4) begin
        if ((i % 2) == 0) c0++;
        else              c1++;
      end
      if (i >= 1) check_resp($sformatf("rr_resp%0d", i - 1), rr_data[i-1], rr_id[i-1], rr_tag[i-1]);
    end
    tick();
    check("rr_drained", RESP_VALID, 1'b0);

    // Backpressure: exactly two accepts, then hold
    RESP_READY = 1'b0;
    drive0(1'b1, OP_ADD, 32'd7, 32'd8, 4'd3);
    drive1(1'b1, OP_SUB, 32'd20, 32'd4, 4'd4);
    settle();
    check("bp_acc0", REQ_READY_0, 1'b1);
    tick();
    drive0(1'b1, OP_ADD, 32'd1, 32'd1, 4'd6);
    settle();
    check("bp_acc1_ready1", REQ_READY_1, 1'b1);
    check("bp_acc1_ready0", REQ_READY_0, 1'b0);
    tick();
    drive1(1'b1, OP_SUB, 32'd9, 32'd2, 4'd7);
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("bp_hold%0d_r0", i), REQ_READY_0, 1'b0);
      check($sformatf("bp_hold%0d_r1", i), REQ_READY_1, 1'b0);
      check($sformatf("bp_hold%0d_data", i), RESP_DATA, 32'd15);
      check($sformatf("bp_hold%0d_alu", i), ALU_IN1, 32'd20);
      tick();
    end
    check_resp("bp_head", 32'd15, 1'b0, 4'd3);
    RESP_READY = 1'b1;
    settle();
    check("bp_rel_ready0", REQ_READY_0, 1'b1);
    tick();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    check_resp("bp_d1", 32'd16, 1'b1, 4'd4);
    settle();
    check("bp_rel_ready1", REQ_READY_1, 1'b1);
    tick();
    drive1(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    check_resp("bp_d2", 32'd2, 1'b0, 4'd6);
    tick();
    check_resp("bp_d3", 32'd7, 1'b1, 4'd7);
    tick();
    check("bp_drained", RESP_VALID, 1'b0);

    // Flush with both stages full and both requesters pending; prio is 0
    RESP_READY = 1'b0;
    drive0(1'b1, OP_ADD, 32'd5, 32'd5, 4'd1);
    tick();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    drive1(1'b1, OP_SUB, 32'd5, 32'd1, 4'd2);
    tick();
    check("fl_full_valid", RESP_VALID, 1'b1);
    drive0(1'b1, OP_ADD, 32'h11, 32'h22, 4'hA);
    drive1(1'b1, OP_SUB, 32'h30, 32'h1, 4'hB);
    RESP_READY = 1'b1;
    FLUSH = 1'b1;
    settle();
    check("fl_ready0", REQ_READY_0, 1'b0);
    check("fl_ready1", REQ_READY_1, 1'b0);
    tick();
    FLUSH = 1'b0;
    settle();
    check("fl_resp_valid", RESP_VALID, 1'b0);
    check("fl_alu_nop", ALU_INSTRUCTION, 5'd0);
    check("fl_prio_ready0", REQ_READY_0, 1'b1);
    check("fl_prio_ready1", REQ_READY_1, 1'b0);
    tick();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    check("fl_no_ghost", RESP_VALID, 1'b0);
    tick();
    check_resp("fl_after", 32'h33, 1'b0, 4'hA);
    tick();

    // Reset mid-stream; prio is 1 here
    drive0(1'b1, OP_ADD, 32'h40, 32'h2, 4'hC);
    drive1(1'b1, OP_BEQ, 32'd3, 32'd3, 4'hF);
    settle();
    check("ms_ready1", REQ_READY_1, 1'b1);
    tick();
    drive1(1'b0, OP_BEQ, 32'd0, 32'd0, 4'd0);
    tick();
    drive1(1'b1, OP_BEQ, 32'd3, 32'd3, 4'hF);
    check_resp("ms_pre", 32'd0, 1'b1, 4'hF);
    check("ms_pre_branch", RESP_BRANCH, 1'b1);
    RST_N = 1'b0;
    settle();
    check("ms_rst_ready0", REQ_READY_0, 1'b0);
    check("ms_rst_ready1", REQ_READY_1, 1'b0);
    tick();
    check("ms_resp_valid", RESP_VALID, 1'b0);
    check("ms_resp_id", RESP_ID, 1'b0);
    check("ms_resp_tag", RESP_TAG, 4'd0);
    check("ms_resp_data", RESP_DATA, 32'd0);
    check("ms_resp_branch", RESP_BRANCH, 1'b0);
    check("ms_alu_instr", ALU_INSTRUCTION, 5'd0);
    check("ms_alu_in2", ALU_IN2, 32'd0);
    RST_N = 1'b1;
    settle();
    check("ms_post_ready0", REQ_READY_0, 1'b1);
    check("ms_post_ready1", REQ_READY_1, 1'b0);
    tick();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0);
    check("ms_no_old_resp", RESP_VALID, 1'b0);
    tick();
    check_resp("ms_post", 32'h42, 1'b0, 4'hC);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
